servo_cmd_parser: RTL and testbench
===================================

// Module: servo_cmd_parser
// PURPOSE
//  Receive side of the servo command link. Takes bytes from the UART receiver and parses
//  fixed 15-char ASCII frames "#iiiPppppTtttt!" (id, pulse us, move time ms).
//  Emits decoded binary fields plus a raw frame image with the same byte packing the
//  transmit-side generator uses. Sits between uart_recv and the servo PWM/control logic.
// PARAMETERS
//  TIMEOUT_CYC  500_000  max sys_clk cycles between bytes inside a frame (10 ms @ 50 MHz)
//  ID_MAX       254      largest legal servo id
//  PW_MIN       500      smallest legal pulse width, us
//  PW_MAX       2500     largest legal pulse width, us
// PORTS
//  sys_clk     in   1    system clock
//  sys_rst_n   in   1    asynchronous reset, active low
//  rx_data     in   8    received byte, valid when rx_valid=1
//  rx_valid    in   1    one-cycle strobe per received byte
//  cmd_valid   out  1    one-cycle pulse: good frame decoded
//  cmd_err     out  1    one-cycle pulse: frame aborted (syntax/range/timeout)
//  servo_id    out  10   decoded id (0..999 range of 3 digits)
//  pulse_us    out  14   decoded pulse width
//  time_ms     out  14   decoded move time
//  cmd_frame   out  120  raw frame; char k (0='#') at bits [8k+7:8k]
//  busy        out  1    1 while inside a frame (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, accumulators and timeout counter 0.
//  States: IDLE -> ID(3 digits) -> SEP_P -> PW(4 digits) -> SEP_T -> TM(4 digits) -> END.
//  IDLE: only '#' (0x23) advances to ID; all other bytes ignored, no error.
//  Digit states: '0'..'9' -> acc <= acc*10 + (byte-0x30); advance after 3rd/4th digit.
//  SEP_P expects 'P' (0x50), SEP_T expects 'T' (0x54), END expects '!' (0x21).
//  Any unexpected byte in a non-IDLE state: cmd_err pulse, return to IDLE; if that byte
//   is '#', enter ID directly instead (resync, new frame starts with this byte).
//  '!' accepted in END: range check id<=ID_MAX, PW_MIN<=pw<=PW_MAX; pass -> next cycle
//   cmd_valid=1 and servo_id/pulse_us/time_ms/cmd_frame updated together; fail -> cmd_err.
//  Latency: cmd_valid/cmd_err asserted exactly 1 cycle after the terminating rx_valid.
//  Decoded outputs hold last good frame until the next good frame; err never alters them.
//  cmd_valid and cmd_err are never both 1.
//  Timeout: counter clears on every rx_valid, counts while busy; reaching TIMEOUT_CYC
//   -> cmd_err pulse, IDLE. rx_valid arriving on the timeout cycle: timeout wins, byte
//   then reprocessed as if in IDLE (so '#' starts a new frame).
//  Frame capture: shift register loads byte at index = char position; cleared on '#'.
//  Back-to-back frames with zero gap after '!' must be accepted.
//  Reset mid-frame: immediate return to IDLE, no pulse on either flag.
// STRUCTURE
//  Shared include servo_cmd_defs.vh: ASCII constants (CH_HASH, CH_P, CH_T, CH_BANG,
//   CH_0, CH_9), state encodings, FRAME_LEN=15.
//  Sub-module servo_dec_accum: clear/load-digit inputs, 14-bit acc*10+d (shift-add,
//   no multiplier), one instance per field or one shared with per-state select.
//  Top: FSM, digit counter (0..3), timeout counter, frame register, output regs.
// TESTING
//  "#000P1500T1000!" -> cmd_valid 1 cycle after '!', id=0, pw=1500, tm=1000,
//   cmd_frame[7:0]=0x23, cmd_frame[119:112]=0x21.
//  "#001P2500T1000!" then "#002P3500T1400!" back-to-back -> valid for first (id=1,
//   pw=2500); second gives cmd_err (pw 3500>PW_MAX), outputs still hold id=1.
//  "#00xP..." -> cmd_err on 'x', busy=0; following "#003P0800T0050!" -> id=3, pw=800, tm=50.
//  "#001P15#004P1200T0100!" -> cmd_err on second '#', then valid id=4, pw=1200, tm=100.
//  "#005P1" then TIMEOUT_CYC idle cycles -> cmd_err exactly at timeout, busy=0.
//  Garbage "ABC" in IDLE -> no pulse; sys_rst_n low mid-frame -> all outputs 0, no err.

Source files
------------

// File: rtl/servo_cmd_parser_pkg.sv
// servo_cmd_parser_pkg
//   Shared definitions for the servo command receive path: ASCII framing
//   characters, default limits, frame length and the parser state type.
//   "#iiiPppppTtttt!" is the only frame shape understood by the parser.
package servo_cmd_parser_pkg;

    localparam int TIMEOUT_CYC_DEF = 500_000;
    localparam int ID_MAX_DEF      = 254;
    localparam int PW_MIN_DEF      = 500;
    localparam int PW_MAX_DEF      = 2500;
    localparam int FRAME_LEN       = 15;
    localparam int ACC_W           = 14;

    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_T    = 8'h54;
    localparam logic [7:0] CH_BANG = 8'h21;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_SEP_P,
        ST_PW,
        ST_SEP_T,
        ST_TM,
        ST_END
    } state_t;

    function automatic logic isDigit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/servo_cmd_parser_dec_accum.sv
// servo_dec_accum
//   Decimal accumulator for one numeric field: acc <= acc*10 + digit.
//   The *10 is built from two shifts and an add so no multiplier is inferred.
// Ports
//   i_clk    system clock
//   i_rst_n  asynchronous reset, active low
//   i_clr    clear the accumulator (start of a new frame)
//   i_load   fold i_digit into the accumulator
//   i_digit  binary value 0..9 of the received ASCII digit
//   o_acc    current accumulated value
module servo_dec_accum
    import servo_cmd_parser_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [3:0]       i_digit,
    output logic [ACC_W-1:0] o_acc
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_accNext;

    // acc*10 = acc*8 + acc*2; at most four digits so 14 bits never overflow
    assign w_accNext = (r_acc << 3) + (r_acc << 1) + ACC_W'(i_digit);

    // Clear has priority so a resync '#' always starts the field from zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= w_accNext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/servo_cmd_parser.sv
// servo_cmd_parser
//   Parses "#iiiPppppTtttt!" frames arriving byte by byte from the UART
//   receiver. A good frame produces a one-cycle cmd_valid together with the
//   decoded id / pulse width / move time and the raw frame image; any syntax,
//   range or inter-byte timeout problem produces a one-cycle cmd_err instead.
// Ports
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   cmd_valid, cmd_err  result pulses, one cycle after the terminating byte
//   servo_id, pulse_us, time_ms  fields of the last good frame
//   cmd_frame           raw last good frame, char k at bits [8k+7:8k]
//   busy                high while a frame is in progress
module servo_cmd_parser
    import servo_cmd_parser_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int ID_MAX      = ID_MAX_DEF,
    parameter int PW_MIN      = PW_MIN_DEF,
    parameter int PW_MAX      = PW_MAX_DEF
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         cmd_valid,
    output logic         cmd_err,
    output logic [9:0]   servo_id,
    output logic [13:0]  pulse_us,
    output logic [13:0]  time_ms,
    output logic [119:0] cmd_frame,
    output logic         busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t           r_state, w_stateNext;
    logic [1:0]       r_digitCnt, w_digitNext;
    logic [3:0]       r_pos, w_posNext;
    logic [119:0]     r_frame, w_frameNext;
    logic [TO_W-1:0]  r_toCnt;
    logic             w_timeout, w_start, w_accept, w_bad, w_valid, w_err;
    logic             w_ldId, w_ldPw, w_ldTm, w_rangeOk;
    logic [ACC_W-1:0] w_id, w_pw, w_tm;

    servo_dec_accum u_accId (.i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_clr(w_start),
                             .i_load(w_ldId), .i_digit(rx_data[3:0]), .o_acc(w_id));
    servo_dec_accum u_accPw (.i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_clr(w_start),
                             .i_load(w_ldPw), .i_digit(rx_data[3:0]), .o_acc(w_pw));
    servo_dec_accum u_accTm (.i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_clr(w_start),
                             .i_load(w_ldTm), .i_digit(rx_data[3:0]), .o_acc(w_tm));

    assign busy      = (r_state != ST_IDLE);
    assign w_timeout = busy && (r_toCnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_rangeOk = (w_id <= ACC_W'(ID_MAX)) &&
                       (w_pw >= ACC_W'(PW_MIN)) && (w_pw <= ACC_W'(PW_MAX));

    // Next-state logic. A timeout forces the byte of the same cycle to be
    // judged as if the parser were already idle, so a '#' there opens a frame.
    always_comb begin
        w_stateNext = r_state;
        w_digitNext = r_digitCnt;
        w_posNext   = r_pos;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_bad       = 1'b0;
        w_valid     = 1'b0;
        w_err       = 1'b0;
        w_ldId      = 1'b0;
        w_ldPw      = 1'b0;
        w_ldTm      = 1'b0;

        if (w_timeout) begin
            w_err       = 1'b1;
            w_stateNext = ST_IDLE;
        end

        if (rx_valid) begin
            if (r_state == ST_IDLE || w_timeout) begin
                w_start = (rx_data == CH_HASH);
            end else begin
                case (r_state)
                    ST_ID: begin
                        if (isDigit(rx_data)) begin
                            w_accept = 1'b1;
                            w_ldId   = 1'b1;
                            if (r_digitCnt == 2'd2) begin
                                w_digitNext = 2'd0;
                                w_stateNext = ST_SEP_P;
                            end else begin
                                w_digitNext = r_digitCnt + 2'd1;
                            end
                        end else begin
                            w_bad = 1'b1;
                        end
                    end
                    ST_PW: begin
                        if (isDigit(rx_data)) begin
                            w_accept = 1'b1;
                            w_ldPw   = 1'b1;
                            w_digitNext = r_digitCnt + 2'd1;
                            if (r_digitCnt == 2'd3) begin
                                w_stateNext = ST_SEP_T;
                            end
                        end else begin
                            w_bad = 1'b1;
                        end
                    end
                    ST_TM: begin
                        if (isDigit(rx_data)) begin
                            w_accept = 1'b1;
                            w_ldTm   = 1'b1;
                            w_digitNext = r_digitCnt + 2'd1;
                            if (r_digitCnt == 2'd3) begin
                                w_stateNext = ST_END;
                            end
                        end else begin
                            w_bad = 1'b1;
                        end
                    end
                    ST_SEP_P: begin
                        w_accept    = (rx_data == CH_P);
                        w_bad       = !w_accept;
                        w_stateNext = ST_PW;
                    end
                    ST_SEP_T: begin
                        w_accept    = (rx_data == CH_T);
                        w_bad       = !w_accept;
                        w_stateNext = ST_TM;
                    end
                    ST_END: begin
                        w_accept    = (rx_data == CH_BANG);
                        w_bad       = !w_accept;
                        w_valid     = w_accept && w_rangeOk;
                        w_err       = w_accept && !w_rangeOk;
                        w_stateNext = ST_IDLE;
                    end
                    default: ;
                endcase

                if (w_bad) begin
                    w_err       = 1'b1;
                    w_stateNext = ST_IDLE;
                    w_start     = (rx_data == CH_HASH);
                end
            end

            if (w_start) begin
                w_stateNext = ST_ID;
                w_digitNext = 2'd0;
                w_posNext   = 4'd1;
            end else if (w_accept) begin
                w_posNext = r_pos + 4'd1;
            end
        end
    end

    // Frame image: '#' wipes it, every accepted byte lands at its char position
    always_comb begin
        w_frameNext = r_frame;
        if (w_start) begin
            w_frameNext = {112'd0, CH_HASH};
        end else if (w_accept) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                if (r_pos == 4'(k)) begin
                    w_frameNext[8*k +: 8] = rx_data;
                end
            end
        end
    end

    // Parser state, counters and frame register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_digitCnt <= 2'd0;
            r_pos      <= 4'd0;
            r_frame    <= '0;
            r_toCnt    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_digitCnt <= w_digitNext;
            r_pos      <= w_posNext;
            r_frame    <= w_frameNext;
            if (rx_valid || !busy || w_timeout) begin
                r_toCnt <= '0;
            end else begin
                r_toCnt <= r_toCnt + TO_W'(1);
            end
        end
    end

    // Result pulses and held decoded outputs; an error never touches the fields
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            servo_id  <= '0;
            pulse_us  <= '0;
            time_ms   <= '0;
            cmd_frame <= '0;
        end else begin
            cmd_valid <= w_valid;
            cmd_err   <= w_err;
            if (w_valid) begin
                servo_id  <= w_id[9:0];
                pulse_us  <= w_pw;
                time_ms   <= w_tm;
                cmd_frame <= w_frameNext;
            end
        end
    end

endmodule

// File: tb/tb_servo_cmd_parser.sv
// tb_servo_cmd_parser
//   Scenario tasks for the servo command parser plus a randomized run checked
//   against a template-matching reference model of the frame format.
module tb_servo_cmd_parser;

    localparam int TB_TIMEOUT = 64;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         cmd_valid, cmd_err, busy;
    logic [9:0]   servo_id;
    logic [13:0]  pulse_us, time_ms;
    logic [119:0] cmd_frame;

    int errors = 0;
    int checks = 0;
    int validCnt, errCnt, errPos;

    // Reference model state
    byte unsigned mBuf[$];
    string        tpl = "#DDDPDDDDTDDDD!";
    int           mId, mPw, mTm;
    logic [119:0] mFrame;
    logic         expValid, expErr;

    servo_cmd_parser #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_err(cmd_err), .servo_id(servo_id), .pulse_us(pulse_us),
        .time_ms(time_ms), .cmd_frame(cmd_frame), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Present one byte for exactly one cycle; outputs are sampled 1 ns after the edge
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sendStr(input string s);
        validCnt = 0;
        errCnt   = 0;
        errPos   = -1;
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i]);
            if (cmd_valid) validCnt++;
            if (cmd_err) begin
                errCnt++;
                errPos = i;
            end
        end
    endtask

    function automatic logic [119:0] packStr(input string s);
        logic [119:0] f;
        f = '0;
        for (int k = 0; k < s.len() && k < 15; k++) f[8*k +: 8] = s[k];
        return f;
    endfunction

    // Reference model: a frame is the 15-char template; a byte either extends
    // the current partial frame or breaks it.
    task automatic modelByte(input logic [7:0] b);
        int  p;
        logic ok;
        int  id, pw, tm;
        p = mBuf.size();
        expValid = 1'b0;
        expErr   = 1'b0;
        if (p == 0) begin
            if (b == 8'h23) mBuf.push_back(b);
        end else begin
            if (tpl[p] == 8'h44) ok = (b >= 8'h30) && (b <= 8'h39);
            else                 ok = (b == tpl[p]);
            if (ok) begin
                mBuf.push_back(b);
                if (mBuf.size() == 15) begin
                    id = 0; pw = 0; tm = 0;
                    for (int k = 1; k <= 3; k++)   id = id * 10 + (mBuf[k] - 48);
                    for (int k = 5; k <= 8; k++)   pw = pw * 10 + (mBuf[k] - 48);
                    for (int k = 10; k <= 13; k++) tm = tm * 10 + (mBuf[k] - 48);
                    if (id <= 254 && pw >= 500 && pw <= 2500) begin
                        expValid = 1'b1;
                        mId = id; mPw = pw; mTm = tm;
                        for (int k = 0; k < 15; k++) mFrame[8*k +: 8] = mBuf[k];
                    end else begin
                        expErr = 1'b1;
                    end
                    mBuf.delete();
                end
            end else begin
                expErr = 1'b1;
                mBuf.delete();
                if (b == 8'h23) mBuf.push_back(b);
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        checks++;
        if ({cmd_valid, cmd_err, busy} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags got %b exp 000", {cmd_valid, cmd_err, busy});
        end
        checks++;
        if ({servo_id, pulse_us, time_ms, cmd_frame} !== '0) begin
            errors++; $display("[TB] FAIL reset_fields got id=%0d pw=%0d tm=%0d exp all 0", servo_id, pulse_us, time_ms);
        end
        sys_rst_n = 1'b1;
        idleCycle();
    endtask

    task automatic test_basic();
        string s;
        s = "#000P1500T1000!";
        sendStr(s);
        checks++;
        if (cmd_valid !== 1'b1 || validCnt != 1 || errCnt != 0) begin
            errors++; $display("[TB] FAIL basic_valid got valid=%b cnt=%0d errs=%0d exp 1/1/0", cmd_valid, validCnt, errCnt);
        end
        checks++;
        if (servo_id !== 10'd0 || pulse_us !== 14'd1500 || time_ms !== 14'd1000) begin
            errors++; $display("[TB] FAIL basic_fields got %0d/%0d/%0d exp 0/1500/1000", servo_id, pulse_us, time_ms);
        end
        checks++;
        if (cmd_frame[7:0] !== 8'h23 || cmd_frame[119:112] !== 8'h21 || cmd_frame !== packStr(s)) begin
            errors++; $display("[TB] FAIL basic_frame got %h exp %h", cmd_frame, packStr(s));
        end
        idleCycle();
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_pulse_width got valid=%b exp 0", cmd_valid);
        end
    endtask

    task automatic test_back_to_back();
        sendStr("#001P2500T1000!");
        checks++;
        if (cmd_valid !== 1'b1 || servo_id !== 10'd1 || pulse_us !== 14'd2500) begin
            errors++; $display("[TB] FAIL b2b_first got valid=%b id=%0d pw=%0d exp 1/1/2500", cmd_valid, servo_id, pulse_us);
        end
        sendStr("#002P3500T1400!");
        checks++;
        if (cmd_err !== 1'b1 || cmd_valid !== 1'b0 || errCnt != 1 || validCnt != 0) begin
            errors++; $display("[TB] FAIL b2b_range got err=%b valid=%b errs=%0d exp 1/0/1", cmd_err, cmd_valid, errCnt);
        end
        checks++;
        if (servo_id !== 10'd1 || pulse_us !== 14'd2500 || time_ms !== 14'd1000) begin
            errors++; $display("[TB] FAIL b2b_hold got %0d/%0d/%0d exp 1/2500/1000", servo_id, pulse_us, time_ms);
        end
    endtask

    task automatic test_syntax_err();
        sendStr("#00x");
        checks++;
        if (cmd_err !== 1'b1 || busy !== 1'b0 || errPos != 3) begin
            errors++; $display("[TB] FAIL syntax_err got err=%b busy=%b pos=%0d exp 1/0/3", cmd_err, busy, errPos);
        end
        sendStr("P15");
        checks++;
        if (errCnt != 0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL syntax_tail got errs=%0d busy=%b exp 0/0", errCnt, busy);
        end
        sendStr("#003P0800T0050!");
        checks++;
        if (cmd_valid !== 1'b1 || servo_id !== 10'd3 || pulse_us !== 14'd800 || time_ms !== 14'd50) begin
            errors++; $display("[TB] FAIL syntax_recover got v=%b %0d/%0d/%0d exp 1 3/800/50", cmd_valid, servo_id, pulse_us, time_ms);
        end
    endtask

    task automatic test_resync();
        sendStr("#001P15#004P1200T0100!");
        checks++;
        if (errCnt != 1 || errPos != 7 || validCnt != 1) begin
            errors++; $display("[TB] FAIL resync_pulses got errs=%0d pos=%0d valids=%0d exp 1/7/1", errCnt, errPos, validCnt);
        end
        checks++;
        if (cmd_valid !== 1'b1 || servo_id !== 10'd4 || pulse_us !== 14'd1200 || time_ms !== 14'd100) begin
            errors++; $display("[TB] FAIL resync_fields got v=%b %0d/%0d/%0d exp 1 4/1200/100", cmd_valid, servo_id, pulse_us, time_ms);
        end
    endtask

    task automatic test_timeout();
        int errAt, nErr;
        logic busyEarly;
        errAt = -1; nErr = 0; busyEarly = 1'b1;
        sendStr("#005P1");
        for (int k = 1; k <= TB_TIMEOUT + 3; k++) begin
            idleCycle();
            if (cmd_err) begin
                nErr++;
                if (errAt < 0) errAt = k;
            end
            if (k < TB_TIMEOUT && !busy) busyEarly = 1'b0;
        end
        checks++;
        if (errAt != TB_TIMEOUT || nErr != 1) begin
            errors++; $display("[TB] FAIL timeout_cycle got at=%0d n=%0d exp at=%0d n=1", errAt, nErr, TB_TIMEOUT);
        end
        checks++;
        if (busy !== 1'b0 || busyEarly !== 1'b1 || pulse_us !== 14'd1200) begin
            errors++; $display("[TB] FAIL timeout_busy got busy=%b early=%b pw=%0d exp 0/1/1200", busy, busyEarly, pulse_us);
        end
        // '#' arriving on the very timeout cycle starts a fresh frame
        sendStr("#006P");
        repeat (TB_TIMEOUT - 1) idleCycle();
        applyStimulus(8'h23);
        checks++;
        if (cmd_err !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL timeout_hash got err=%b busy=%b exp 1/1", cmd_err, busy);
        end
        sendStr("007P1000T0200!");
        checks++;
        if (cmd_valid !== 1'b1 || servo_id !== 10'd7 || pulse_us !== 14'd1000 || time_ms !== 14'd200) begin
            errors++; $display("[TB] FAIL timeout_newframe got v=%b %0d/%0d/%0d exp 1 7/1000/200", cmd_valid, servo_id, pulse_us, time_ms);
        end
    endtask

    task automatic test_garbage();
        sendStr("ABC");
        idleCycle();
        checks++;
        if (errCnt != 0 || validCnt != 0 || busy !== 1'b0 || cmd_err !== 1'b0) begin
            errors++; $display("[TB] FAIL garbage got errs=%0d valids=%0d busy=%b exp 0/0/0", errCnt, validCnt, busy);
        end
    endtask

    task automatic test_reset_midframe();
        logic sawPulse;
        sawPulse = 1'b0;
        sendStr("#008P12");
        sys_rst_n = 1'b0;
        #2;
        checks++;
        if ({cmd_valid, cmd_err, busy} !== 3'b000 || {servo_id, pulse_us, time_ms, cmd_frame} !== '0) begin
            errors++; $display("[TB] FAIL midreset_outputs got busy=%b id=%0d pw=%0d exp all 0", busy, servo_id, pulse_us);
        end
        repeat (2) idleCycle();
        sys_rst_n = 1'b1;
        repeat (3) begin
            idleCycle();
            if (cmd_err || cmd_valid || busy) sawPulse = 1'b1;
        end
        checks++;
        if (sawPulse !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_quiet got activity=%b exp 0", sawPulse);
        end
    endtask

    task automatic test_random();
        string s, junk;
        int    id, pw, tm, gap;
        logic [7:0] b;
        junk = "0123456789#PT!xA ";
        mBuf.delete();
        mId = 0; mPw = 0; mTm = 0; mFrame = '0;
        for (int f = 0; f < 40; f++) begin
            id = $urandom_range(0, 320);
            pw = $urandom_range(0, 3200);
            tm = $urandom_range(0, 9999);
            s  = $sformatf("#%03dP%04dT%04d!", id, pw, tm);
            if ($urandom_range(0, 4) == 0) s.putc($urandom_range(1, 14), junk[$urandom_range(0, junk.len() - 1)]);
            if ($urandom_range(0, 5) == 0) s = {junk.substr($urandom_range(11, 16), 16), s};
            for (int i = 0; i < s.len(); i++) begin
                b = s[i];
                applyStimulus(b);
                modelByte(b);
                checks++;
                if (cmd_valid !== expValid || cmd_err !== expErr) begin
                    errors++; $display("[TB] FAIL rand_pulse f%0d c%0d got v=%b e=%b exp v=%b e=%b", f, i, cmd_valid, cmd_err, expValid, expErr);
                end
                checks++;
                if (servo_id !== 10'(mId) || pulse_us !== 14'(mPw) || time_ms !== 14'(mTm) || cmd_frame !== mFrame) begin
                    errors++; $display("[TB] FAIL rand_fields f%0d c%0d got %0d/%0d/%0d exp %0d/%0d/%0d", f, i, servo_id, pulse_us, time_ms, mId, mPw, mTm);
                end
                checks++;
                if (busy !== (mBuf.size() != 0)) begin
                    errors++; $display("[TB] FAIL rand_busy f%0d c%0d got %b exp %b", f, i, busy, mBuf.size() != 0);
                end
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                idleCycle();
                checks++;
                if (cmd_valid !== 1'b0 || cmd_err !== 1'b0) begin
                    errors++; $display("[TB] FAIL rand_gap f%0d got v=%b e=%b exp 0/0", f, cmd_valid, cmd_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_syntax_err();
        test_resync();
        test_timeout();
        test_garbage();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
